// File: rtl/clk_div_sched.sv
// Runtime controller for the even-ratio clock divider: ratio handshake,
// glitch-free start/stop and ratio changes aligned to clk_out low boundaries.
module clk_div_sched #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             cfg_err,
    output logic [CNT_W-1:0] div_cur
);

    typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;

    logic xfer, ok, wrap, fall;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= CNT_W'(DEFAULT_DIV / 2);
            div_q   <= CNT_W'(DEFAULT_DIV);
            pend_q  <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // The counter runs on half_q, which only reloads on a falling toggle
    // or in IDLE, so a ratio written during STOP cannot shorten a phase.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        div_d     = div_q;
        pend_d    = pend_q;
        clk_d     = clk_q;
        tick_d    = 1'b0;
        err_d     = 1'b0;
        cfg_ready = (state_q != PEND);
        xfer      = cfg_valid & cfg_ready;
        ok        = ~cfg_div[0] & (|cfg_div[CNT_W-1:1]);
        wrap      = (cnt_q == half_q - CNT_W'(1));
        fall      = wrap & clk_q;

        if (xfer && !ok) err_d = 1'b1;

        if (state_q != IDLE) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (wrap) clk_d = ~clk_q;
            tick_d = wrap & ~clk_q;
            if (fall) half_d = div_q >> 1;
        end

        unique case (state_q)
            IDLE: begin
                clk_d = 1'b0;
                cnt_d = '0;
                if (xfer && ok) div_d = cfg_div;
                half_d = ((xfer && ok) ? cfg_div : div_q) >> 1;
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (xfer && ok) begin
                    pend_d  = cfg_div;
                    state_d = PEND;
                end else if (!enable) begin
                    if (!clk_q || fall) begin
                        state_d = IDLE;
                        clk_d   = 1'b0;
                        cnt_d   = '0;
                        tick_d  = 1'b0;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
            PEND: begin
                if (fall) begin
                    div_d   = pend_q;
                    half_d  = pend_q >> 1;
                    state_d = enable ? RUN : IDLE;
                end
            end
            STOP: begin
                if (xfer && ok) div_d = cfg_div;
                if (enable) state_d = RUN;
                else if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign cfg_err = err_q;
    assign active  = (state_q != IDLE);
    assign div_cur = div_q;

endmodule
